r4_sdf_input_collector: RTL and testbench

- Upstream feeder for the radix-4 pipelined butterfly.
- Accepts a serial stream of complex samples, one per valid cycle, in N-point frames.
- Buffers the first three quarters of each frame.
- During the last quarter, issues one butterfly operand set per valid input: a=x[k], b=x[k+N/4], c=x[k+N/2], d=x[k+3N/4].
- Issues twiddle indices for W^k, W^2k and W^3k alongside each set, plus a start strobe that drives the butterfly's start input.

---
 rtl/r4_sdf_input_collector.sv | 150 +++++++++++++++
 tb/tb_r4_sdf_input_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/r4_sdf_input_collector.sv
// Input collector for the radix-4 SDF butterfly: buffers quarters 0..2 of each
// frame and, during quarter 3, issues one operand set plus twiddle indices per valid sample.
module r4_sdf_input_collector #(
    parameter int WIDTH = 32,
    parameter int N     = 64,
    parameter int LOG2N = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic signed [WIDTH-1:0] ar,
    output logic signed [WIDTH-1:0] ai,
    output logic signed [WIDTH-1:0] br,
    output logic signed [WIDTH-1:0] bi,
    output logic signed [WIDTH-1:0] cr,
    output logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] dr,
    output logic signed [WIDTH-1:0] di,
    output logic        [LOG2N-1:0] tw0_idx,
    output logic        [LOG2N-1:0] tw1_idx,
    output logic        [LOG2N-1:0] tw2_idx,
    output logic                    start,
    output logic                    last,
    output logic                    sof_err
);
    localparam int QN = N / 4;
    localparam int KW = (LOG2N > 2) ? LOG2N - 2 : 1;
    localparam logic [LOG2N-1:0] K_MASK = LOG2N'(QN - 1);

    // Quarter buffers hold {re, im}; read asynchronously so the operand
    // registers below are the only latency stage.
    logic [2*WIDTH-1:0] q0_mem [QN];
    logic [2*WIDTH-1:0] q1_mem [QN];
    logic [2*WIDTH-1:0] q2_mem [QN];

    logic [LOG2N-1:0] cnt_q, cnt_d, eff_cnt, k_full;
    logic [1:0]       quarter;
    logic [KW-1:0]    k;
    logic             accept_sof, resync, issue;

    logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q, cr_q, ci_q, dr_q, di_q;
    logic signed [WIDTH-1:0] ar_d, ai_d, br_d, bi_d, cr_d, ci_d, dr_d, di_d;
    logic [LOG2N-1:0]        tw0_q, tw1_q, tw2_q, tw0_d, tw1_d, tw2_d;
    logic                    start_q, last_q, sof_err_q;
    logic                    start_d, last_d, sof_err_d;

    always_comb begin
        accept_sof = in_valid & in_sof;
        resync     = accept_sof & (cnt_q != '0);
        // A framing strobe forces this sample to index 0 regardless of cnt.
        eff_cnt    = accept_sof ? '0 : cnt_q;
        quarter    = eff_cnt[LOG2N-1 -: 2];
        k_full     = eff_cnt & K_MASK;
        k          = k_full[KW-1:0];
        issue      = in_valid & (quarter == 2'd3);
        cnt_d      = in_valid ? eff_cnt + LOG2N'(1) : cnt_q;
    end

    always_comb begin
        ar_d      = ar_q;
        ai_d      = ai_q;
        br_d      = br_q;
        bi_d      = bi_q;
        cr_d      = cr_q;
        ci_d      = ci_q;
        dr_d      = dr_q;
        di_d      = di_q;
        tw0_d     = tw0_q;
        tw1_d     = tw1_q;
        tw2_d     = tw2_q;
        start_d   = issue;
        last_d    = issue && (k_full == K_MASK);
        sof_err_d = resync;
        if (issue) begin
            ar_d  = q0_mem[k][2*WIDTH-1:WIDTH];
            ai_d  = q0_mem[k][WIDTH-1:0];
            br_d  = q1_mem[k][2*WIDTH-1:WIDTH];
            bi_d  = q1_mem[k][WIDTH-1:0];
            cr_d  = q2_mem[k][2*WIDTH-1:WIDTH];
            ci_d  = q2_mem[k][WIDTH-1:0];
            dr_d  = in_re;
            di_d  = in_im;
            // 3k never exceeds 3N/4-3, so no wrap is needed in LOG2N bits.
            tw0_d = k_full;
            tw1_d = k_full << 1;
            tw2_d = k_full + (k_full << 1);
        end
    end

    always_ff @(posedge clock) begin
        if (in_valid && quarter == 2'd0) q0_mem[k] <= {in_re, in_im};
        if (in_valid && quarter == 2'd1) q1_mem[k] <= {in_re, in_im};
        if (in_valid && quarter == 2'd2) q2_mem[k] <= {in_re, in_im};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
            cr_q      <= '0;
            ci_q      <= '0;
            dr_q      <= '0;
            di_q      <= '0;
            tw0_q     <= '0;
            tw1_q     <= '0;
            tw2_q     <= '0;
            start_q   <= 1'b0;
            last_q    <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ar_q      <= ar_d;
            ai_q      <= ai_d;
            br_q      <= br_d;
            bi_q      <= bi_d;
            cr_q      <= cr_d;
            ci_q      <= ci_d;
            dr_q      <= dr_d;
            di_q      <= di_d;
            tw0_q     <= tw0_d;
            tw1_q     <= tw1_d;
            tw2_q     <= tw2_d;
            start_q   <= start_d;
            last_q    <= last_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign ar      = ar_q;
    assign ai      = ai_q;
    assign br      = br_q;
    assign bi      = bi_q;
    assign cr      = cr_q;
    assign ci      = ci_q;
    assign dr      = dr_q;
    assign di      = di_q;
    assign tw0_idx = tw0_q;
    assign tw1_idx = tw1_q;
    assign tw2_idx = tw2_q;
    assign start   = start_q;
    assign last    = last_q;
    assign sof_err = sof_err_q;

endmodule

// File: tb/tb_r4_sdf_input_collector.sv
// Scoreboard bench for r4_sdf_input_collector at N=16: a frame-level reference
// model queues expected operand sets as samples are driven.
module tb_r4_sdf_input_collector;
    localparam int WIDTH = 32;
    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int QN    = N / 4;
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef struct {
        logic signed [WIDTH-1:0] ar, ai, br, bi, cr, ci, dr, di;
        logic [LOG2N-1:0]        t0, t1, t2;
        logic                    last;
    } set_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_sof = 1'b0;
    logic signed [WIDTH-1:0] in_re = '0;
    logic signed [WIDTH-1:0] in_im = '0;
    logic signed [WIDTH-1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic [LOG2N-1:0]        tw0_idx, tw1_idx, tw2_idx;
    logic                    start, last, sof_err;

    r4_sdf_input_collector #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
        .tw0_idx(tw0_idx), .tw1_idx(tw1_idx), .tw2_idx(tw2_idx),
        .start(start), .last(last), .sof_err(sof_err)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    set_t sb[$];
    set_t hold_set;
    int   m_cnt = 0;
    logic signed [WIDTH-1:0] m_re [3][QN];
    logic signed [WIDTH-1:0] m_im [3][QN];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_set(input string pfx, input set_t e);
        check_val({pfx, ".ar"}, ar, e.ar);
        check_val({pfx, ".ai"}, ai, e.ai);
        check_val({pfx, ".br"}, br, e.br);
        check_val({pfx, ".bi"}, bi, e.bi);
        check_val({pfx, ".cr"}, cr, e.cr);
        check_val({pfx, ".ci"}, ci, e.ci);
        check_val({pfx, ".dr"}, dr, e.dr);
        check_val({pfx, ".di"}, di, e.di);
        check_val({pfx, ".tw0"}, tw0_idx, e.t0);
        check_val({pfx, ".tw1"}, tw1_idx, e.t1);
        check_val({pfx, ".tw2"}, tw2_idx, e.t2);
    endtask

    function automatic set_t zero_set();
        set_t z;
        z.ar = '0; z.ai = '0; z.br = '0; z.bi = '0;
        z.cr = '0; z.ci = '0; z.dr = '0; z.di = '0;
        z.t0 = '0; z.t1 = '0; z.t2 = '0; z.last = 1'b0;
        return z;
    endfunction

    // One clock: model the sample, drive it, then compare outputs 1 ns after the edge.
    task automatic step(input logic v, input logic s,
                        input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im);
        logic exp_start, exp_err;
        int   q, k;
        set_t e;
        exp_start = 1'b0;
        exp_err   = 1'b0;
        if (v) begin
            if (s) begin
                if (m_cnt != 0) exp_err = 1'b1;
                m_cnt = 0;
            end
            q = m_cnt / QN;
            k = m_cnt % QN;
            if (q < 3) begin
                m_re[q][k] = re;
                m_im[q][k] = im;
            end else begin
                e.ar = m_re[0][k]; e.ai = m_im[0][k];
                e.br = m_re[1][k]; e.bi = m_im[1][k];
                e.cr = m_re[2][k]; e.ci = m_im[2][k];
                e.dr = re;         e.di = im;
                e.t0 = LOG2N'(k); e.t1 = LOG2N'(2 * k); e.t2 = LOG2N'(3 * k);
                e.last = (k == QN - 1);
                sb.push_back(e);
                exp_start = 1'b1;
            end
            m_cnt = (m_cnt + 1) % N;
        end
        in_valid = v;
        in_sof   = s;
        in_re    = re;
        in_im    = im;
        @(posedge clock);
        #1;
        check_val("start", start, exp_start);
        check_val("sof_err", sof_err, exp_err);
        if (start) begin
            start_cnt++;
            if (sb.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check_set("set", e);
                check_val("last", last, e.last);
                hold_set = e;
            end
        end else begin
            check_val("last_idle", last, 0);
            check_set("hold", hold_set);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_cnt = 0;
        sb.delete();
        hold_set = zero_set();
        check_val("rst.start", start, 0);
        check_val("rst.last", last, 0);
        check_val("rst.sof_err", sof_err, 0);
        check_set("rst", hold_set);
    endtask

    task automatic frame(input int base, input logic first_sof, input logic bubbles);
        for (int n = 0; n < N; n++) begin
            step(1'b1, first_sof && n == 0, WIDTH'(base + n), -WIDTH'(base + n));
            if (bubbles) step(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom));
        end
    endtask

    initial begin
        hold_set = zero_set();
        do_reset();
        do_reset();

        // Ramp frame, continuous.
        frame(0, 1'b1, 1'b0);
        check_val("ramp.starts", start_cnt, 4);

        // Same frame with a bubble after every sample.
        start_cnt = 0;
        frame(0, 1'b1, 1'b1);
        check_val("bubble.starts", start_cnt, 4);

        // Two back-to-back frames, sof only on the first.
        start_cnt = 0;
        frame(0, 1'b1, 1'b0);
        frame(100, 1'b0, 1'b0);
        check_val("b2b.starts", start_cnt, 8);

        // Resync: sof arrives at sample 6, then 15 more samples complete the frame.
        start_cnt = 0;
        for (int n = 0; n < 6; n++) step(1'b1, n == 0, WIDTH'(n), -WIDTH'(n));
        step(1'b1, 1'b1, 200, -200);
        for (int n = 1; n < N; n++) step(1'b1, 1'b0, WIDTH'(200 + n), -WIDTH'(200 + n));
        check_val("resync.starts", start_cnt, 4);

        // Reset after sample 13, then a fresh frame.
        for (int n = 0; n < 14; n++) step(1'b1, n == 0, WIDTH'(n), -WIDTH'(n));
        do_reset();
        start_cnt = 0;
        frame(300, 1'b1, 1'b0);
        check_val("postrst.starts", start_cnt, 4);

        // Extreme values in every quarter.
        for (int n = 0; n < N; n++)
            step(1'b1, n == 0, (n % 2 == 0) ? S_MIN : WIDTH'(n), (n % 3 == 0) ? S_MAX : S_MIN);
        step(1'b0, 1'b0, '0, '0);
        check_val("sb.empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end
endmodule
